// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: data/register-file sizing, instruction field
// positions and the register index type.
package rv_pkg;

   localparam int XLEN     = 32;
   localparam int NUM_REGS = 32;
   localparam int IDX_W    = $clog2(NUM_REGS);

   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;
   localparam int RD_LSB  = 7;

   typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports with write-first
// bypass, one synchronous write port, x0 hardwired to zero, registered write ack.
module register_file
   import rv_pkg::*;
#(
   parameter int XLEN     = rv_pkg::XLEN,
   parameter int NUM_REGS = rv_pkg::NUM_REGS
)
(
   input  logic            clock,
   input  logic            reset,
   input  logic            writeEnable,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] writeData,
   output logic [XLEN-1:0] rs1Data,
   output logic [XLEN-1:0] rs2Data,
   output logic            writeBackComplete
);

   reg_idx_t rs1;
   reg_idx_t rs2;
   reg_idx_t rd;

   // Entry 0 is never stored; reads of x0 are forced to zero below.
   logic [XLEN-1:0] regs [1:NUM_REGS-1];

   logic wr_live;

   assign rs1 = instruction[RS1_LSB +: IDX_W];
   assign rs2 = instruction[RS2_LSB +: IDX_W];
   assign rd  = instruction[RD_LSB  +: IDX_W];

   // Opcode and funct fields play no part in register addressing.
   logic unused_fields;
   assign unused_fields = ^{instruction[31:25], instruction[14:12], instruction[6:0]};

   assign wr_live = writeEnable && (rd != '0);

   always_comb begin
      rs1Data = '0;
      if (wr_live && (rd == rs1)) begin
         rs1Data = writeData;
      end else if (rs1 != '0) begin
         rs1Data = regs[rs1];
      end
   end

   always_comb begin
      rs2Data = '0;
      if (wr_live && (rd == rs2)) begin
         rs2Data = writeData;
      end else if (rs2 != '0) begin
         rs2Data = regs[rs2];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         writeBackComplete <= 1'b0;
      end else begin
         writeBackComplete <= writeEnable;
         if (wr_live) begin
            regs[rd] <= writeData;
         end
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by a
// randomized run compared against an array-based architectural model.
module tb_register_file;

   logic        clock;
   logic        reset;
   logic        writeEnable;
   logic [31:0] instruction;
   logic [31:0] writeData;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        writeBackComplete;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [32];
   logic        exp_wbc;

   register_file dut (
      .clock             (clock),
      .reset             (reset),
      .writeEnable       (writeEnable),
      .instruction       (instruction),
      .writeData         (writeData),
      .rs1Data           (rs1Data),
      .rs2Data           (rs2Data),
      .writeBackComplete (writeBackComplete)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] make_instr(input int r1, input int r2, input int rdi,
                                              input logic [31:0] junk);
      logic [31:0] w;
      w = junk;
      w[24:20] = 5'(r2);
      w[19:15] = 5'(r1);
      w[11:7]  = 5'(rdi);
      return w;
   endfunction

   // Architectural read: x0 is zero, a live write to the same index wins.
   function automatic logic [31:0] arch_read(input int idx);
      int rdi;
      rdi = int'(instruction[11:7]);
      if (idx == 0) return 32'h0;
      if (writeEnable && rdi != 0 && rdi == idx) return writeData;
      return model[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reads(input string tag);
      #1;
      check({tag, "_rs1"}, rs1Data, arch_read(int'(instruction[19:15])));
      check({tag, "_rs2"}, rs2Data, arch_read(int'(instruction[24:20])));
   endtask

   // One clock edge: update the model from the inputs the DUT samples.
   task automatic tick();
      int rdi;
      @(posedge clock);
      rdi = int'(instruction[11:7]);
      if (reset) begin
         for (int i = 0; i < 32; i++) model[i] = 32'h0;
         exp_wbc = 1'b0;
      end else begin
         exp_wbc = writeEnable;
         if (writeEnable && rdi != 0) model[rdi] = writeData;
      end
      #1;
   endtask

   task automatic write_reg(input int rdi, input logic [31:0] d);
      instruction = make_instr(0, 0, rdi, 32'h0000_0033);
      writeData   = d;
      writeEnable = 1'b1;
      tick();
      writeEnable = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      writeEnable = 1'b0;
      instruction = 32'h0;
      writeData   = 32'h0;
      exp_wbc     = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'h0;

      #1;
      check("x0_before_reset", rs1Data, 32'h0);

      tick();
      tick();
      reset = 1'b0;
      check("reset_wbc", {31'h0, writeBackComplete}, 32'h0);
      for (int i = 0; i < 32; i++) begin
         instruction = make_instr(i, 31 - i, 0, 32'h0);
         #1;
         check("reset_rs1", rs1Data, 32'h0);
         check("reset_rs2", rs2Data, 32'h0);
      end

      // Write then read back, with a one-cycle acknowledge.
      instruction = make_instr(0, 0, 2, 32'h0);
      writeData   = 32'hFFFF_FFFF;
      writeEnable = 1'b1;
      tick();
      writeEnable = 1'b0;
      check("wb_ack_high", {31'h0, writeBackComplete}, 32'h1);
      instruction = make_instr(2, 0, 0, 32'h0);
      #1;
      check("readback_x2", rs1Data, 32'hFFFF_FFFF);
      tick();
      check("wb_ack_low", {31'h0, writeBackComplete}, 32'h0);

      // Writes to x0 are acknowledged but discarded.
      instruction = make_instr(0, 0, 0, 32'h0);
      writeData   = 32'hDEAD_BEEF;
      writeEnable = 1'b1;
      #1;
      check("x0_no_bypass", rs1Data, 32'h0);
      tick();
      writeEnable = 1'b0;
      check("x0_wb_ack", {31'h0, writeBackComplete}, 32'h1);
      #1;
      check("x0_rs1", rs1Data, 32'h0);
      check("x0_rs2", rs2Data, 32'h0);

      // Write-first bypass on rs2, old value still on rs1 from another index.
      write_reg(6, 32'h1111_1111);
      instruction = make_instr(2, 6, 6, 32'h0);
      writeData   = 32'h2222_2222;
      writeEnable = 1'b1;
      #1;
      check("bypass_rs2", rs2Data, 32'h2222_2222);
      check("bypass_rs1_other", rs1Data, 32'hFFFF_FFFF);
      tick();
      writeEnable = 1'b0;
      instruction = make_instr(6, 6, 0, 32'h0);
      #1;
      check("after_bypass_x6", rs1Data, 32'h2222_2222);
      check("same_index_ports", rs2Data, 32'h2222_2222);

      // Dual read of distinct registers.
      write_reg(4, 32'hA5A5_A5A5);
      write_reg(7, 32'h5A5A_5A5A);
      instruction = make_instr(4, 7, 0, 32'h0);
      #1;
      check("dual_rs1_x4", rs1Data, 32'hA5A5_A5A5);
      check("dual_rs2_x7", rs2Data, 32'h5A5A_5A5A);

      // Reset beats a coincident write.
      write_reg(3, 32'hCAFE_0003);
      instruction = make_instr(0, 0, 3, 32'h0);
      writeData   = 32'h0000_1234;
      writeEnable = 1'b1;
      reset       = 1'b1;
      tick();
      reset       = 1'b0;
      writeEnable = 1'b0;
      check("rst_prio_wbc", {31'h0, writeBackComplete}, 32'h0);
      instruction = make_instr(3, 4, 0, 32'h0);
      #1;
      check("rst_prio_x3", rs1Data, 32'h0);
      check("rst_prio_x4", rs2Data, 32'h0);

      // Randomized traffic against the model, including opcode/funct noise.
      for (int n = 0; n < 400; n++) begin
         instruction = make_instr($urandom_range(31), $urandom_range(31),
                                  $urandom_range(31), $urandom);
         writeData   = $urandom;
         writeEnable = ($urandom_range(3) != 0);
         reset       = ($urandom_range(60) == 0);
         check_reads("rand");
         tick();
         check("rand_wbc", {31'h0, writeBackComplete}, {31'h0, exp_wbc});
      end
      reset       = 1'b0;
      writeEnable = 1'b0;
      for (int i = 0; i < 32; i++) begin
         instruction = make_instr(i, (i + 13) % 32, 0, 32'h0);
         check_reads("final_sweep");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
